// File: rtl/snac_db15_reader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// SnacDb15Reader (module snac_db15_reader)
//
// Serial reader for the SNAC DB15 joystick adapter on the user port. It
// clocks the adapter's shift-register chain and captures 24 bits per frame,
// 12 bits per player. A frame must match the previous frame before it is
// shown, which rejects single-frame glitches.
//
// Ports:
//   i_clk       in   1  core clock (53.6 MHz)
//   RESETn      in   1  synchronous active-low reset
//   JOY_DATA    in   1  serial data from the adapter, 0 = pressed
//   JOY_CLK     out  1  shift clock to the adapter, idles high
//   JOY_LOAD    out  1  parallel-load strobe to the adapter, active high
//   joystick1   out 16  player 1 buttons, active high, bits 15:12 zero
//   joystick2   out 16  player 2 buttons, same layout
//   frame_done  out  1  one-cycle pulse at the end of every frame
//
// Parameters:
//   CLK_DIV    i_clk cycles per JOY_CLK half-period (one "tick"), 2..65535
//   GAP_TICKS  idle ticks between frames, 1..255
// ---------------------------------------------------------------------------
module snac_db15_reader #(
   parameter int CLK_DIV   = 134,
   parameter int GAP_TICKS = 16
) (
   input  logic        i_clk,
   input  logic        RESETn,
   input  logic        JOY_DATA,
   output logic        JOY_CLK,
   output logic        JOY_LOAD,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        frame_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;

   logic [15:0] r_divCnt;
   logic [7:0]  r_gapCnt;
   logic        r_loadCnt;
   logic [4:0]  r_bitIdx;
   logic        r_half;
   logic [23:0] r_sr;
   logic [23:0] r_prev;
   logic [11:0] r_joy1;
   logic [11:0] r_joy2;
   logic        r_joyClk;
   logic        r_joyLoad;

   logic        w_tick;
   logic        w_gapDone;
   logic        w_lastBit;
   logic [23:0] w_frame;
   logic        w_joyClkNext;
   logic        w_joyLoadNext;

   assign w_tick    = (r_divCnt == 16'(CLK_DIV - 1));
   assign w_gapDone = (r_gapCnt == 8'(GAP_TICKS - 1));
   assign w_lastBit = (r_bitIdx == 5'd23);
   assign w_frame   = ~r_sr;

   assign JOY_CLK   = r_joyClk;
   assign JOY_LOAD  = r_joyLoad;
   assign joystick1 = {4'b0000, r_joy1};
   assign joystick2 = {4'b0000, r_joy2};

   // State register: the FSM restarts in IDLE whenever reset is sampled low.
   always_ff @(posedge i_clk) begin
      if (!RESETn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state logic: every transition waits for a tick except DONE,
   // which lasts exactly one core-clock cycle.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_tick && w_gapDone)            w_stateNext = LOAD;
         LOAD:    if (w_tick && r_loadCnt)            w_stateNext = SHIFT;
         SHIFT:   if (w_tick && r_half && w_lastBit)  w_stateNext = DONE;
         DONE:                                        w_stateNext = IDLE;
         default:                                     w_stateNext = IDLE;
      endcase
   end

   // Output logic: frame_done decodes the DONE state directly; the JOY_*
   // pins are computed here as next values and then registered so the
   // adapter sees glitch-free edges.
   always_comb begin
      frame_done    = (r_state == DONE);
      w_joyClkNext  = r_joyClk;
      w_joyLoadNext = r_joyLoad;
      case (r_state)
         IDLE: begin
            w_joyClkNext  = 1'b1;
            w_joyLoadNext = w_tick && w_gapDone;
         end
         LOAD: begin
            if (w_tick && r_loadCnt) begin
               w_joyClkNext  = 1'b0;
               w_joyLoadNext = 1'b0;
            end else begin
               w_joyClkNext  = 1'b1;
               w_joyLoadNext = 1'b1;
            end
         end
         SHIFT: begin
            w_joyLoadNext = 1'b0;
            if (w_tick) begin
               // End of a low half raises the clock; end of a high half drops
               // it again unless the last bit has just been taken.
               w_joyClkNext = !r_half || w_lastBit;
            end
         end
         DONE: begin
            w_joyClkNext  = 1'b1;
            w_joyLoadNext = 1'b0;
         end
         default: begin
            w_joyClkNext  = 1'b1;
            w_joyLoadNext = 1'b0;
         end
      endcase
   end

   // Datapath: tick divider, frame counters, shift capture and the
   // two-frame glitch filter. The divider is frozen during DONE so the
   // DONE cycle adds one cycle to the frame instead of stealing one from
   // the following gap.
   always_ff @(posedge i_clk) begin
      if (!RESETn) begin
         r_divCnt  <= 16'd0;
         r_gapCnt  <= 8'd0;
         r_loadCnt <= 1'b0;
         r_bitIdx  <= 5'd0;
         r_half    <= 1'b0;
         r_sr      <= 24'hFFFFFF;
         r_prev    <= 24'd0;
         r_joy1    <= 12'd0;
         r_joy2    <= 12'd0;
         r_joyClk  <= 1'b1;
         r_joyLoad <= 1'b0;
      end else begin
         r_joyClk  <= w_joyClkNext;
         r_joyLoad <= w_joyLoadNext;
         if (r_state != DONE) begin
            r_divCnt <= w_tick ? 16'd0 : r_divCnt + 16'd1;
         end
         case (r_state)
            IDLE: begin
               r_loadCnt <= 1'b0;
               if (w_tick) begin
                  r_gapCnt <= w_gapDone ? 8'd0 : r_gapCnt + 8'd1;
               end
            end
            LOAD: begin
               if (w_tick) begin
                  r_loadCnt <= 1'b1;
                  if (r_loadCnt) begin
                     r_bitIdx <= 5'd0;
                     r_half   <= 1'b0;
                  end
               end
            end
            SHIFT: begin
               if (w_tick) begin
                  if (!r_half) begin
                     r_sr[r_bitIdx] <= JOY_DATA;
                     r_half         <= 1'b1;
                  end else if (!w_lastBit) begin
                     r_bitIdx <= r_bitIdx + 5'd1;
                     r_half   <= 1'b0;
                  end
               end
            end
            DONE: begin
               // Only a frame identical to its predecessor reaches the pins.
               if (w_frame == r_prev) begin
                  r_joy1 <= w_frame[11:0];
                  r_joy2 <= w_frame[23:12];
               end
               r_prev   <= w_frame;
               r_gapCnt <= 8'd0;
            end
            default: begin
               r_gapCnt <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snac_db15_reader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// TbSnacDb15Reader (module tb_snac_db15_reader)
//
// Directed bench for snac_db15_reader with CLK_DIV=4, GAP_TICKS=2. A small
// adapter model shifts out a 24-bit active-low pattern on JOY_CLK rising
// edges after each JOY_LOAD. Expected joystick words come from a filter
// model and are queued when a frame's pattern is chosen, then popped and
// compared on the cycle after frame_done.
// ---------------------------------------------------------------------------
module tb_snac_db15_reader;

   localparam int ClkDiv   = 4;
   localparam int GapTicks = 2;
   localparam int FramePeriod = (2 + 48 + GapTicks) * ClkDiv + 1;

   logic        i_clk = 1'b0;
   logic        RESETn;
   logic        JOY_DATA;
   logic        JOY_CLK;
   logic        JOY_LOAD;
   logic [15:0] joystick1;
   logic [15:0] joystick2;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;

   // Adapter model state
   logic [23:0] pending = 24'hFFFFFF;
   logic [23:0] curFrame = 24'hFFFFFF;
   int          edgeCnt = 0;
   time         fallTime = 0;
   int          lowLen = 0;

   // Filter model and scoreboard
   logic [23:0] mPrev = 24'd0;
   logic [11:0] mJ1 = 12'd0;
   logic [11:0] mJ2 = 12'd0;
   logic [31:0] sbQ[$];
   time         lastDone = 0;
   bit          periodValid = 0;

   snac_db15_reader #(
      .CLK_DIV   (ClkDiv),
      .GAP_TICKS (GapTicks)
   ) dut (
      .i_clk      (i_clk),
      .RESETn     (RESETn),
      .JOY_DATA   (JOY_DATA),
      .JOY_CLK    (JOY_CLK),
      .JOY_LOAD   (JOY_LOAD),
      .joystick1  (joystick1),
      .joystick2  (joystick2),
      .frame_done (frame_done)
   );

   always #5 i_clk = ~i_clk;

   // The adapter latches its pattern on the load strobe and presents bit k
   // after the k-th rising edge of JOY_CLK.
   always @(posedge JOY_LOAD) begin
      curFrame = pending;
      edgeCnt  = 0;
   end

   always @(posedge JOY_CLK) begin
      edgeCnt = edgeCnt + 1;
      lowLen  = int'(($time - fallTime) / 10);
   end

   always @(negedge JOY_CLK) begin
      fallTime = $time;
   end

   assign JOY_DATA = (edgeCnt < 24) ? curFrame[edgeCnt[4:0]] : 1'b1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Chooses the pattern for the next frame, queues the filtered outcome,
   // then waits for that frame to end and checks it.
   task automatic applyStimulus(input logic [23:0] pressed, input string tag);
      logic [31:0] exp;
      bit          got;
      pending = ~pressed;
      if (pressed == mPrev) begin
         mJ1 = pressed[11:0];
         mJ2 = pressed[23:12];
      end
      mPrev = pressed;
      sbQ.push_back({4'b0000, mJ1, 4'b0000, mJ2});
      got = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge i_clk);
         if (frame_done) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
         void'(sbQ.pop_front());
         return;
      end
      checkOutput({tag, "_edges"}, 32'(edgeCnt), 32'd24);
      checkOutput({tag, "_lowhalf"}, 32'(lowLen), 32'(ClkDiv));
      if (periodValid) begin
         checkOutput({tag, "_period"}, 32'(($time - lastDone) / 10), 32'(FramePeriod));
      end
      lastDone    = $time;
      periodValid = 1;
      @(negedge i_clk);
      exp = sbQ.pop_front();
      checkOutput({tag, "_j1"}, {16'd0, joystick1}, {16'd0, exp[31:16]});
      checkOutput({tag, "_j2"}, {16'd0, joystick2}, {16'd0, exp[15:0]});
      checkOutput({tag, "_donefall"}, {31'd0, frame_done}, 32'd0);
   endtask

   // Directed sequence: reset, idle frames, bit mapping, glitch, release,
   // and a reset in the middle of a shift.
   initial begin
      int  loadAt;
      bit  hit;
      RESETn  = 1'b0;
      pending = 24'hFFFFFF;
      repeat (3) @(posedge i_clk);
      #1;
      checkOutput("rst_clk",  {31'd0, JOY_CLK},    32'd1);
      checkOutput("rst_load", {31'd0, JOY_LOAD},   32'd0);
      checkOutput("rst_j1",   {16'd0, joystick1},  32'd0);
      checkOutput("rst_j2",   {16'd0, joystick2},  32'd0);
      checkOutput("rst_done", {31'd0, frame_done}, 32'd0);

      @(negedge i_clk);
      RESETn = 1'b1;
      loadAt = 0;
      for (int n = 1; n <= 50; n++) begin
         @(posedge i_clk);
         #1;
         if (JOY_LOAD) begin
            loadAt = n;
            break;
         end
      end
      checkOutput("first_load", 32'(loadAt), 32'(GapTicks * ClkDiv));

      applyStimulus(24'h000000, "idle0");
      applyStimulus(24'h000000, "idle1");
      applyStimulus(24'h000000, "idle2");

      applyStimulus(24'h008010, "map0");
      applyStimulus(24'h008010, "map1");
      applyStimulus(24'h000000, "maprel0");
      applyStimulus(24'h000000, "maprel1");

      applyStimulus(24'h000400, "glitch");
      applyStimulus(24'h000000, "glpost0");
      applyStimulus(24'h000000, "glpost1");

      applyStimulus(24'h000800, "sel0");
      applyStimulus(24'h000800, "sel1");
      applyStimulus(24'h000800, "sel2");
      applyStimulus(24'h000000, "selrel0");
      applyStimulus(24'h000000, "selrel1");

      applyStimulus(24'h000801, "pre0");
      applyStimulus(24'h000801, "pre1");

      // Let the next frame shift halfway, then pull reset.
      pending = ~24'h000801;
      hit = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge i_clk);
         if (edgeCnt == 12 && !JOY_LOAD) begin
            hit = 1;
            break;
         end
      end
      checkOutput("mid_reached", {31'd0, hit}, 32'd1);
      RESETn = 1'b0;
      @(posedge i_clk);
      #1;
      checkOutput("mid_j1",   {16'd0, joystick1},  32'd0);
      checkOutput("mid_j2",   {16'd0, joystick2},  32'd0);
      checkOutput("mid_clk",  {31'd0, JOY_CLK},    32'd1);
      checkOutput("mid_load", {31'd0, JOY_LOAD},   32'd0);
      mPrev       = 24'd0;
      mJ1         = 12'd0;
      mJ2         = 12'd0;
      periodValid = 0;
      @(negedge i_clk);
      RESETn = 1'b1;

      applyStimulus(24'h000801, "post0");
      applyStimulus(24'h000801, "post1");

      checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
